round_sequencer: RTL and testbench
==================================

// Module: round_sequencer
// PURPOSE
//  Sequences turns for the fighting-game core. It collects one action from each
//  player and presents both to the core as a single action1/action2 pair with a
//  one-cycle actionEnable strobe. It then waits for the core's result and stops the
//  match once firstWin or secondWin is seen. It sits between the player input logic
//  and the game core, and it is the only block that drives actionEnable.
// PARAMETERS
//  TIMEOUT_CYCLES  1000    cycles allowed after the first submission before the missing player is forced
//  SETTLE_CYCLES   2       cycles to wait after the strobe before sampling firstWin/secondWin (>=1)
//  IDLE_ACTION     3'b000  action code substituted for a player who times out
//  ROUND_W         8       width of round_count
// PORTS
//  clk          in   1        system clock, rising edge
//  resetGame    in   1        asynchronous reset, active-low
//  p1_req       in   1        player 1 submit strobe (sampled each edge)
//  p1_action    in   3        player 1 action code, valid with p1_req
//  p2_req       in   1        player 2 submit strobe
//  p2_action    in   3        player 2 action code, valid with p2_req
//  firstWin     in   1        from game core: player 1 has won
//  secondWin    in   1        from game core: player 2 has won
//  action1      out  3        to core: latched player 1 action
//  action2      out  3        to core: latched player 2 action
//  actionEnable out  1        to core: one-cycle turn strobe
//  p1_locked    out  1        player 1 action accepted for the current turn
//  p2_locked    out  1        player 2 action accepted for the current turn
//  timeout_flag out  1        the last issued turn used IDLE_ACTION for a player
//  round_count  out  ROUND_W  number of turns issued, saturating
//  match_over   out  1        a winner has been detected
// BEHAVIOUR
//  - Reset (resetGame=0, async): state=COLLECT; all outputs 0; action1=action2=IDLE_ACTION;
//    timer cleared. Reset asserted mid-turn aborts the turn; no strobe is emitted.
//  - All outputs are registered.
//  - FSM states: COLLECT, ISSUE, SETTLE, OVER.
//  - COLLECT:
//    - p1_req while !p1_locked: latch p1_action into action1 and set p1_locked. Player 2 is symmetric.
//    - Requests from an already-locked player are ignored; the first submission stands.
//    - The timer starts on the edge the first lock is taken. It does not run while neither player is locked.
//    - Both locked, including both reqs on the same edge: go to ISSUE.
//    - Timer reaches TIMEOUT_CYCLES-1 with one player locked: load IDLE_ACTION into the missing
//      action, set timeout_flag, go to ISSUE.
//    - A req on the same edge as the timeout wins: the real action is used and timeout_flag stays 0.
//    - firstWin|secondWin high in COLLECT: go to OVER.
//  - ISSUE (exactly 1 cycle):
//    - actionEnable=1. round_count += 1, saturating at all-ones.
//    - Go to SETTLE.
//    - Latency: the edge that completes both locks makes actionEnable high for the following cycle.
//  - SETTLE:
//    - actionEnable=0. action1/action2 held stable.
//    - Count SETTLE_CYCLES, then sample the win inputs.
//    - Either win input high: go to OVER. Otherwise go to COLLECT with locks, timer and
//      timeout_flag cleared; action outputs are kept.
//  - OVER:
//    - match_over=1. actionEnable stays 0. All reqs ignored.
//    - Leaves only on reset.
//  - timeout_flag is cleared on the next lock in COLLECT.
//  - Requests arriving in ISSUE or SETTLE are dropped, not queued.
// TESTING
//  T1: reset low 5ns, then high; p1_req(3'b110) and p2_req(3'b100) on the same edge -> actionEnable
//      high exactly 1 cycle next cycle, action1=110, action2=100, round_count=1.
//  T2: p1_req(001), p1_req(111) 3 cycles later, then p2_req(011) -> action1=001 (second p1 req
//      ignored), action2=011, a single strobe.
//  T3: p1_req(001) only, TIMEOUT_CYCLES=8 -> strobe 8 cycles after the lock, action2=000,
//      timeout_flag=1; flag clears on the next lock.
//  T4: core raises firstWin during SETTLE -> match_over=1; further reqs give no strobe and no
//      round_count change until reset.
//  T5: resetGame pulsed low during SETTLE -> all outputs reset immediately (async); next turn
//      counts from round_count=1.
//  T6: ROUND_W=2, issue 5 turns -> round_count saturates at 3.

Source files
------------

// File: rtl/round_sequencer.sv
// Turn sequencer for the fighting-game core: gathers one action per player,
// strobes the pair into the core, then watches for a winner.
module round_sequencer #(
  parameter int         TIMEOUT_CYCLES = 1000,
  parameter int         SETTLE_CYCLES  = 2,
  parameter logic [2:0] IDLE_ACTION    = 3'b000,
  parameter int         ROUND_W        = 8
) (
  input  logic               clk,
  input  logic               resetGame,
  input  logic               p1_req,
  input  logic [2:0]         p1_action,
  input  logic               p2_req,
  input  logic [2:0]         p2_action,
  input  logic               firstWin,
  input  logic               secondWin,
  output logic [2:0]         action1,
  output logic [2:0]         action2,
  output logic               actionEnable,
  output logic               p1_locked,
  output logic               p2_locked,
  output logic               timeout_flag,
  output logic [ROUND_W-1:0] round_count,
  output logic               match_over
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] SLAST = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    COLLECT, ISSUE, SETTLE, OVER
  } state_t;

  state_t state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [SW-1:0] scnt, scnt_n;
  logic [2:0] a1_n, a2_n;
  logic en_n, l1_n, l2_n, tf_n, ov_n;
  logic [ROUND_W-1:0] rc_n;
  logic take1, take2, win;

  assign take1 = p1_req && !p1_locked;
  assign take2 = p2_req && !p2_locked;
  assign win   = firstWin | secondWin;

  always_comb begin
    state_n = state;
    timer_n = timer;
    scnt_n  = scnt;
    a1_n    = action1;
    a2_n    = action2;
    en_n    = 1'b0;
    l1_n    = p1_locked;
    l2_n    = p2_locked;
    tf_n    = timeout_flag;
    ov_n    = match_over;
    rc_n    = round_count;
    unique case (state)
      COLLECT: begin
        if (win) begin
          state_n = OVER;
          ov_n    = 1'b1;
        end else begin
          if (take1) begin
            a1_n = p1_action;
            l1_n = 1'b1;
          end
          if (take2) begin
            a2_n = p2_action;
            l2_n = 1'b1;
          end
          if (take1 || take2) tf_n = 1'b0;
          if (p1_locked ^ p2_locked) timer_n = timer + TW'(1);
          // A real late submission beats the timeout on the same edge
          if (!(l1_n && l2_n) && (p1_locked ^ p2_locked)
              && timer == TLAST) begin
            if (!l1_n) a1_n = IDLE_ACTION;
            if (!l2_n) a2_n = IDLE_ACTION;
            l1_n = 1'b1;
            l2_n = 1'b1;
            tf_n = 1'b1;
          end
          if (l1_n && l2_n) begin
            state_n = ISSUE;
            en_n    = 1'b1;
            if (!(&round_count)) rc_n = round_count + ROUND_W'(1);
          end
        end
      end
      ISSUE: begin
        state_n = SETTLE;
        scnt_n  = '0;
      end
      SETTLE: begin
        if (scnt == SLAST) begin
          if (win) begin
            state_n = OVER;
            ov_n    = 1'b1;
          end else begin
            state_n = COLLECT;
            l1_n    = 1'b0;
            l2_n    = 1'b0;
            tf_n    = 1'b0;
            timer_n = '0;
          end
        end else begin
          scnt_n = scnt + SW'(1);
        end
      end
      OVER: begin
        state_n = OVER;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetGame) begin
    if (!resetGame) begin
      state        <= COLLECT;
      timer        <= '0;
      scnt         <= '0;
      action1      <= IDLE_ACTION;
      action2      <= IDLE_ACTION;
      actionEnable <= 1'b0;
      p1_locked    <= 1'b0;
      p2_locked    <= 1'b0;
      timeout_flag <= 1'b0;
      round_count  <= '0;
      match_over   <= 1'b0;
    end else begin
      state        <= state_n;
      timer        <= timer_n;
      scnt         <= scnt_n;
      action1      <= a1_n;
      action2      <= a2_n;
      actionEnable <= en_n;
      p1_locked    <= l1_n;
      p2_locked    <= l2_n;
      timeout_flag <= tf_n;
      round_count  <= rc_n;
      match_over   <= ov_n;
    end
  end

endmodule

// File: tb/tb_round_sequencer.sv
// Bench for round_sequencer: turn-level reference model driven by
// per-player submission times, with random spurious and dropped requests.
module tb_round_sequencer;

  localparam int TO = 8;
  localparam logic [2:0] IDLE = 3'b000;

  logic       clk = 1'b0;
  logic       resetGame = 1'b0;
  logic       p1_req = 1'b0, p2_req = 1'b0;
  logic [2:0] p1_action = '0, p2_action = '0;
  logic       firstWin = 1'b0, secondWin = 1'b0;
  logic [2:0] action1, action2;
  logic       actionEnable, p1_locked, p2_locked;
  logic       timeout_flag, match_over;
  logic [1:0] round_count;

  int cmp = 0;
  int mis = 0;
  int nturns = 0;

  round_sequencer #(
    .TIMEOUT_CYCLES(TO),
    .SETTLE_CYCLES(2),
    .IDLE_ACTION(IDLE),
    .ROUND_W(2)
  ) dut (
    .clk(clk),
    .resetGame(resetGame),
    .p1_req(p1_req),
    .p1_action(p1_action),
    .p2_req(p2_req),
    .p2_action(p2_action),
    .firstWin(firstWin),
    .secondWin(secondWin),
    .action1(action1),
    .action2(action2),
    .actionEnable(actionEnable),
    .p1_locked(p1_locked),
    .p2_locked(p2_locked),
    .timeout_flag(timeout_flag),
    .round_count(round_count),
    .match_over(match_over)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] rc_exp(input int n);
    return (n > 3) ? 2'd3 : 2'(n);
  endfunction

  task automatic quiet();
    p1_req = 0;
    p2_req = 0;
    firstWin = 0;
    secondWin = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    resetGame = 0;
    quiet();
    #3;
    cmp++;
    if ({actionEnable, p1_locked, p2_locked, timeout_flag,
         match_over} !== 5'b0) begin
      mis++;
      $display("FAIL reset_flags got %b want 00000",
               {actionEnable, p1_locked, p2_locked,
                timeout_flag, match_over});
    end
    cmp++;
    if ({action1, action2, round_count} !== {IDLE, IDLE, 2'd0}) begin
      mis++;
      $display("FAIL reset_vals got a1=%b a2=%b rc=%0d want %b %b 0",
               action1, action2, round_count, IDLE, IDLE);
    end
    @(negedge clk);
    resetGame = 1;
    nturns = 0;
  endtask

  // t1/t2: edge index of each player's real submission, -1 = never
  task automatic run_turn(input int t1, input int t2,
                          input logic [2:0] a1, input logic [2:0] a2,
                          input bit win, input string tag);
    int E;
    bit pr1, pr2, ef;
    logic [2:0] e1, e2;
    logic [1:0] erc, el;
    if (t1 < 0) E = t2 + TO;
    else if (t2 < 0) E = t1 + TO;
    else if ((t1 > t2 ? t1 - t2 : t2 - t1) <= TO)
      E = (t1 > t2) ? t1 : t2;
    else E = ((t1 < t2) ? t1 : t2) + TO;
    pr1 = (t1 >= 0) && (t1 <= E);
    pr2 = (t2 >= 0) && (t2 <= E);
    e1 = pr1 ? a1 : IDLE;
    e2 = pr2 ? a2 : IDLE;
    ef = !(pr1 && pr2);
    for (int e = 0; e <= E + 3; e++) begin
      p1_req = (e == t1)
            || (pr1 && e > t1 && e <= E
                && (e == t1 + 3 || $urandom_range(2) == 0))
            || (e > E && $urandom_range(1) == 1);
      p2_req = (e == t2)
            || (pr2 && e > t2 && e <= E && $urandom_range(2) == 0)
            || (e > E && $urandom_range(1) == 1);
      p1_action = (e == t1) ? a1 : 3'($urandom);
      p2_action = (e == t2) ? a2 : 3'($urandom);
      firstWin = win && (e > E);
      @(posedge clk);
      #1;
      cmp++;
      if (actionEnable !== (e == E)) begin
        mis++;
        $display("FAIL %s strobe e=%0d got %b want %b",
                 tag, e, actionEnable, (e == E));
      end
      erc = rc_exp(e >= E ? nturns + 1 : nturns);
      cmp++;
      if (round_count !== erc) begin
        mis++;
        $display("FAIL %s round_count e=%0d got %0d want %0d",
                 tag, e, round_count, erc);
      end
      if (e < E) begin
        el = {t1 >= 0 && e >= t1, t2 >= 0 && e >= t2};
        cmp++;
        if ({p1_locked, p2_locked} !== el) begin
          mis++;
          $display("FAIL %s locks e=%0d got %b want %b",
                   tag, e, {p1_locked, p2_locked}, el);
        end
      end
      if (e == E) begin
        cmp++;
        if ({action1, action2, timeout_flag} !== {e1, e2, ef}) begin
          mis++;
          $display("FAIL %s issue got a1=%b a2=%b tf=%b want %b %b %b",
                   tag, action1, action2, timeout_flag, e1, e2, ef);
        end
      end
      if (e == E + 3) begin
        cmp++;
        if (win && match_over !== 1'b1) begin
          mis++;
          $display("FAIL %s match_over got %b want 1", tag, match_over);
        end else if (!win && {p1_locked, p2_locked, timeout_flag,
                              match_over, action1, action2}
                     !== {4'b0, e1, e2}) begin
          mis++;
          $display("FAIL %s settle_exit got l=%b%b tf=%b mo=%b a=%b/%b",
                   tag, p1_locked, p2_locked, timeout_flag,
                   match_over, action1, action2);
        end
      end
    end
    nturns++;
    quiet();
  endtask

  task automatic test_same_edge();
    run_turn(0, 0, 3'b110, 3'b100, 0, "same_edge");
  endtask

  task automatic test_first_stands();
    run_turn(0, 4, 3'b001, 3'b011, 0, "first_stands");
    run_turn(3, 1, 3'b101, 3'b010, 0, "first_stands_p2");
  endtask

  task automatic test_timeout();
    run_turn(0, -1, 3'b001, 3'b111, 0, "timeout_p2");
    run_turn(2, 1, 3'b100, 3'b011, 0, "after_timeout");
    run_turn(-1, 1, 3'b111, 3'b110, 0, "timeout_p1");
  endtask

  task automatic test_timeout_race();
    run_turn(1, 9, 3'b010, 3'b101, 0, "race_req_wins");
    run_turn(10, 1, 3'b011, 3'b110, 0, "race_late_drop");
  endtask

  task automatic test_win_over();
    logic [1:0] rc0;
    run_turn(0, 1, 3'b101, 3'b001, 1, "win_settle");
    rc0 = rc_exp(nturns);
    for (int i = 0; i < 15; i++) begin
      p1_req = 1'($urandom);
      p2_req = 1'($urandom);
      p1_action = 3'($urandom);
      p2_action = 3'($urandom);
      @(posedge clk);
      #1;
      cmp++;
      if ({actionEnable, match_over, round_count} !== {2'b01, rc0}) begin
        mis++;
        $display("FAIL over_hold i=%0d got en=%b mo=%b rc=%0d want 0 1 %0d",
                 i, actionEnable, match_over, round_count, rc0);
      end
    end
    quiet();
  endtask

  task automatic test_collect_win();
    test_reset();
    secondWin = 1;
    @(posedge clk);
    #1;
    secondWin = 0;
    cmp++;
    if (match_over !== 1'b1) begin
      mis++;
      $display("FAIL collect_win match_over got %b want 1", match_over);
    end
    p1_req = 1;
    p2_req = 1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      cmp++;
      if ({actionEnable, round_count} !== 3'b000) begin
        mis++;
        $display("FAIL collect_win_hold got en=%b rc=%0d want 0 0",
                 actionEnable, round_count);
      end
    end
    quiet();
  endtask

  task automatic test_reset_settle();
    test_reset();
    p1_req = 1;
    p2_req = 1;
    p1_action = 3'b111;
    p2_action = 3'b101;
    @(posedge clk);
    #1;
    quiet();
    @(posedge clk);
    #3;
    resetGame = 0;
    #1;
    cmp++;
    if ({actionEnable, p1_locked, p2_locked, timeout_flag, match_over,
         round_count, action1, action2} !== {7'b0, IDLE, IDLE}) begin
      mis++;
      $display("FAIL async_reset got en=%b l=%b%b rc=%0d a=%b/%b",
               actionEnable, p1_locked, p2_locked, round_count,
               action1, action2);
    end
    @(negedge clk);
    resetGame = 1;
    nturns = 0;
    run_turn(0, 2, 3'b010, 3'b100, 0, "after_reset");
  endtask

  task automatic test_reset_abort();
    test_reset();
    p1_req = 1;
    p1_action = 3'b110;
    @(posedge clk);
    #1;
    quiet();
    repeat (3) @(posedge clk);
    #2;
    resetGame = 0;
    @(negedge clk);
    resetGame = 1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      cmp++;
      if ({actionEnable, p1_locked, round_count} !== 4'b0) begin
        mis++;
        $display("FAIL reset_abort i=%0d got en=%b l1=%b rc=%0d want 0",
                 i, actionEnable, p1_locked, round_count);
      end
    end
  endtask

  task automatic test_saturate();
    test_reset();
    for (int i = 0; i < 5; i++)
      run_turn(0, 0, 3'($urandom), 3'($urandom), 0, "saturate");
  endtask

  task automatic test_random();
    int m, t1, t2;
    for (int i = 0; i < 30; i++) begin
      m = $urandom_range(4);
      t1 = $urandom_range(4);
      t2 = $urandom_range(4);
      case (m)
        1: t2 = t1 + TO;
        2: t1 = t2 + TO + 1;
        3: t2 = -1;
        4: t1 = -1;
        default: ;
      endcase
      run_turn(t1, t2, 3'($urandom), 3'($urandom), 0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_same_edge();
    test_first_stands();
    test_timeout();
    test_timeout_race();
    test_win_over();
    test_collect_win();
    test_reset_settle();
    test_reset_abort();
    test_saturate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end

endmodule
